// File: rtl/serial_adder_nbits.sv
// Digit-serial adder/subtractor, LSB first.
// Word-parallel operands are latched on acceptance, then DIGIT bits per cycle
// ripple through a small adder with the carry held in a flop between digits.
// The finished word plus carry-out and signed overflow are presented in DONE
// until the consumer takes them.
module serial_adder_nbits #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int NCYC  = WIDTH / DIGIT;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    // Reject geometries that cannot be split into whole digits.
    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_nbits: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
    logic [WIDTH-1:0] res_reg;    // partial result, fills from the top
    logic [WIDTH-1:0] f_reg;
    logic             carry_reg;
    logic             co_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [DIGIT:0]   c_chain;    // carries inside the current digit
    logic [DIGIT-1:0] sum_digit;
    logic [WIDTH-1:0] res_next;
    logic             last_digit;

    // Ripple adder across one digit; c_chain[DIGIT-1] is the carry into the
    // top bit of the digit, which on the last digit is the carry into the MSB.
    assign c_chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
            assign sum_digit[gi]  = a_reg[gi] ^ b_reg[gi] ^ c_chain[gi];
            assign c_chain[gi+1]  = (a_reg[gi] & b_reg[gi])
                                  | (c_chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // New digit enters at the top so that after NCYC shifts the LSB digit
    // has arrived at bit 0.
    assign res_next   = (res_reg >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));
    assign last_digit = (cnt_reg == CNT_W'(NCYC - 1));

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign f         = f_reg;
    assign co        = co_reg;
    assign ovf       = ovf_reg;

    // Control FSM together with the operand, carry and result datapath.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            f_reg     <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        // Subtraction is a + ~b + 1 - borrow_in.
                        carry_reg <= ci ^ sub;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= c_chain[DIGIT];
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_digit) begin
                        f_reg     <= res_next;
                        co_reg    <= c_chain[DIGIT];
                        ovf_reg   <= c_chain[DIGIT] ^ c_chain[DIGIT-1];
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_nbits.sv
// Testbench for serial_adder_nbits: directed vectors on a 32x1 instance,
// plus model-checked operations on 32x4 and 8x8 instances.
module tb_serial_adder_nbits;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset;

    // WIDTH=32, DIGIT=1
    logic        m_in_valid, m_in_ready, m_ci, m_sub, m_out_valid, m_out_ready, m_co, m_ovf, m_busy;
    logic [31:0] m_a, m_b, m_f;
    // WIDTH=32, DIGIT=4
    logic        p_in_valid, p_in_ready, p_ci, p_sub, p_out_valid, p_out_ready, p_co, p_ovf, p_busy;
    logic [31:0] p_a, p_b, p_f;
    // WIDTH=8, DIGIT=8
    logic        q_in_valid, q_in_ready, q_ci, q_sub, q_out_valid, q_out_ready, q_co, q_ovf, q_busy;
    logic [7:0]  q_a, q_b, q_f;

    serial_adder_nbits #(.WIDTH(32), .DIGIT(1)) u_m (
        .clk(clk), .n_reset(n_reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .ci(m_ci), .sub(m_sub), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .f(m_f), .co(m_co), .ovf(m_ovf), .busy(m_busy)
    );
    serial_adder_nbits #(.WIDTH(32), .DIGIT(4)) u_p (
        .clk(clk), .n_reset(n_reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .ci(p_ci), .sub(p_sub), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .f(p_f), .co(p_co), .ovf(p_ovf), .busy(p_busy)
    );
    serial_adder_nbits #(.WIDTH(8), .DIGIT(8)) u_q (
        .clk(clk), .n_reset(n_reset), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .a(q_a), .b(q_b), .ci(q_ci), .sub(q_sub), .out_valid(q_out_valid),
        .out_ready(q_out_ready), .f(q_f), .co(q_co), .ovf(q_ovf), .busy(q_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference arithmetic on w-bit operands: returns {co, ovf, f}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub);
        longint unsigned mask, ua, ub, r, fres;
        logic            c, o, sa, sb, sf;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        if (!sub) begin
            r    = ua + ub + {63'd0, ci};
            c    = r[w];
            fres = r & mask;
        end else begin
            fres = (ua - ub - {63'd0, ci}) & mask;
            c    = (ua >= ub + {63'd0, ci});
        end
        sa = ua[w-1];
        sb = ub[w-1];
        sf = fres[w-1];
        o  = sub ? ((sa != sb) && (sf != sa)) : ((sa == sb) && (sf != sa));
        return {c, o, fres[31:0]};
    endfunction

    // Present operands to the 32x1 instance and let them be accepted.
    task automatic m_accept(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
        for (int i = 0; i < 100 && !m_in_ready; i++) begin
            @(posedge clk); #1;
        end
        m_a = a; m_b = b; m_ci = ci; m_sub = sub; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
    endtask

    // Count edges from acceptance to out_valid, then compare result.
    task automatic m_wait_done(input string tag, input logic [33:0] exp);
        int cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (m_out_valid) begin cyc = i; break; end
        end
        check({tag, "_lat"}, 64'(cyc), 64'd32);
        check({tag, "_res"}, {30'd0, m_co, m_ovf, m_f}, {30'd0, exp});
        $display("op %s: f=%h co=%b ovf=%b lat=%0d", tag, m_f, m_co, m_ovf, cyc);
    endtask

    task automatic m_take();
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_out_ready = 1'b0;
    endtask

    task automatic m_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sub, input logic [33:0] exp);
        m_accept(a, b, ci, sub);
        m_wait_done(tag, exp);
        m_take();
    endtask

    task automatic p_op(input int n);
        logic [31:0] a, b;
        logic        ci, sub;
        logic [33:0] exp;
        int          cyc = 0;
        a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
        exp = model(32, a, b, ci, sub);
        p_a = a; p_b = b; p_ci = ci; p_sub = sub; p_in_valid = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        p_a = $urandom; p_b = $urandom; p_ci = ~ci; p_sub = ~sub;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (p_out_valid) begin cyc = i; break; end
        end
        check("p_lat", 64'(cyc), 64'd8);
        check("p_res", {30'd0, p_co, p_ovf, p_f}, {30'd0, exp});
        $display("p%0d a=%h b=%h ci=%b sub=%b -> f=%h co=%b ovf=%b", n, a, b, ci, sub, p_f, p_co, p_ovf);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        p_out_ready = 1'b1;
        @(posedge clk); #1;
        p_out_ready = 1'b0;
    endtask

    task automatic q_op(input int n);
        logic [31:0] a, b;
        logic        ci, sub;
        logic [33:0] exp;
        int          cyc = 0;
        a = {24'd0, 8'($urandom)}; b = {24'd0, 8'($urandom)};
        ci = 1'($urandom); sub = 1'($urandom);
        exp = model(8, a, b, ci, sub);
        q_a = a[7:0]; q_b = b[7:0]; q_ci = ci; q_sub = sub; q_in_valid = 1'b1;
        @(posedge clk); #1;
        q_in_valid = 1'b0;
        q_a = 8'($urandom); q_b = 8'($urandom);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (q_out_valid) begin cyc = i; break; end
        end
        check("q_lat", 64'(cyc), 64'd1);
        check("q_res", {30'd0, q_co, q_ovf, 24'd0, q_f}, {30'd0, exp});
        $display("q%0d a=%h b=%h ci=%b sub=%b -> f=%h co=%b ovf=%b", n, a[7:0], b[7:0], ci, sub, q_f, q_co, q_ovf);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        q_out_ready = 1'b1;
        @(posedge clk); #1;
        q_out_ready = 1'b0;
    endtask

    initial begin
        m_in_valid = 0; m_out_ready = 0; m_a = 0; m_b = 0; m_ci = 0; m_sub = 0;
        p_in_valid = 0; p_out_ready = 0; p_a = 0; p_b = 0; p_ci = 0; p_sub = 0;
        q_in_valid = 0; q_out_ready = 0; q_a = 0; q_b = 0; q_ci = 0; q_sub = 0;
        n_reset = 1'b1;
        #3 n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // {in_ready, out_valid, busy, co, ovf, f}
        check("reset_state", {m_in_ready, m_out_valid, m_busy, m_co, m_ovf, m_f},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk) n_reset = 1'b1;
        @(posedge clk); #1;

        // Carry wrap, signed overflow, carry-in, subtraction with and without borrow.
        m_op("wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00000000});
        m_op("ovf_add",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h80000000});
        m_op("ci_add",   32'h00000001, 32'h00000002, 1'b1, 1'b0, {1'b0, 1'b0, 32'h00000004});
        m_op("sub_neg",  32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE});
        m_op("ovf_sub",  32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF});
        m_op("sub_bin",  32'h00000007, 32'h00000005, 1'b1, 1'b1, {1'b1, 1'b0, 32'h00000001});
        m_op("neg_ovf",  32'h80000000, 32'h80000000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h00000000});

        // Backpressure: result must hold while new operands wave around at the input.
        m_accept(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        m_wait_done("bp", {1'b0, 1'b0, 32'h23456789});
        for (int i = 0; i < 10; i++) begin
            m_in_valid = 1'b1; m_a = $urandom; m_b = $urandom; m_ci = 1'($urandom); m_sub = 1'($urandom);
            @(posedge clk); #1;
            check("bp_hold", {m_in_ready, m_out_valid, m_co, m_ovf, m_f},
                  {1'b0, 1'b1, 1'b0, 1'b0, 32'h23456789});
        end
        m_a = 32'h0000000A; m_b = 32'h00000005; m_ci = 1'b0; m_sub = 1'b0;
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_out_ready = 1'b0;
        check("bp_release", {m_in_ready, m_out_valid, m_busy}, {1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        check("bp_accept", {m_in_ready, m_busy}, {1'b0, 1'b1});
        m_wait_done("bp_next", {1'b0, 1'b0, 32'h0000000F});
        m_take();

        // Asynchronous reset in the middle of RUN.
        m_accept(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("rst_async", {m_in_ready, m_out_valid, m_busy, m_co, m_ovf, m_f},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {m_out_valid, m_busy, m_f}, {1'b0, 1'b0, 32'h0});
        @(negedge clk) n_reset = 1'b1;
        @(posedge clk); #1;
        m_op("after_rst", 32'h00000003, 32'h00000004, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000007});

        // Wider digits against the reference model.
        for (int n = 0; n < 1000; n++) p_op(n);
        for (int n = 0; n < 1000; n++) q_op(n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
